// File: rtl/ov7670_config_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ov7670_config_sequencer
//
// Power-up and register-configuration sequencer for an OV7670 camera.
// It generates the sensor clock (xclk) and holds the sensor in reset, then lets
// it settle. After that it walks an external synchronous register table and
// hands each {reg,value} write to an SCCB byte sender. Table entries:
//   16'hFFFF        end tag: configuration complete
//   16'hF0nn        delay tag: pause nn * DELAY_UNIT clk cycles
//   anything else   register write {reg[15:8], value[7:0]}
// Once in DONE, a start pulse re-runs the table from address 0. The sensor is
// not power-cycled again.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   start             1-cycle pulse; re-run the table (honoured only in DONE)
//   tbl_addr          table read address (AW bits)
//   tbl_data          table entry, valid one cycle after tbl_addr changes
//   snd_send          command request to the SCCB sender
//   snd_id            SCCB write address (constant CAMERA_ADDR)
//   snd_reg, snd_val  register address / value of the pending command
//   snd_taken         1-cycle pulse: the sender accepted the current command
//   cam_reset         sensor reset, active-low
//   cam_pwdn          sensor power-down, tied inactive
//   xclk              sensor clock, clk / XCLK_DIV, 50% duty
//   busy              high whenever configuration is not complete
//   config_finished   high once the table has been fully walked
//   cmd_count         register writes completed in the current run
// -----------------------------------------------------------------------------
module ov7670_config_sequencer #(
  parameter logic [7:0] CAMERA_ADDR   = 8'h42,
  parameter int         XCLK_DIV      = 2,
  parameter int         TABLE_DEPTH   = 64,
  parameter int         RESET_CYCLES  = 1000,
  parameter int         SETTLE_CYCLES = 100000,
  parameter int         DELAY_UNIT    = 1000,
  localparam int        AW            = $clog2(TABLE_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] tbl_addr,
  input  logic [15:0]   tbl_data,
  output logic          snd_send,
  output logic [7:0]    snd_id,
  output logic [7:0]    snd_reg,
  output logic [7:0]    snd_val,
  input  logic          snd_taken,
  output logic          cam_reset,
  output logic          cam_pwdn,
  output logic          xclk,
  output logic          busy,
  output logic          config_finished,
  output logic [AW:0]   cmd_count
);

  // ---------------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------------
  localparam int CW     = AW + 1;
  localparam int PMAX   = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int PW     = (PMAX > 1) ? $clog2(PMAX + 1) : 1;
  localparam int DW     = $clog2(255 * DELAY_UNIT + 1);
  localparam int HALF   = XCLK_DIV / 2;
  localparam int XW     = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [PW-1:0] RST_LAST    = PW'(RESET_CYCLES - 1);
  localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DLY_UNIT_W  = DW'(DELAY_UNIT);
  localparam logic [XW-1:0] XCLK_LAST   = XW'(HALF - 1);

  typedef enum logic [2:0] {
    ST_RST,
    ST_SETTLE,
    ST_FETCH,
    ST_DECODE,
    ST_SEND,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   pwr_cnt;
  logic [DW-1:0]   dly_cnt;
  logic [XW-1:0]   xclk_cnt;

  // Table entry classification, meaningful only in DECODE.
  logic            is_end;
  logic            is_delay;

  assign is_end   = (tbl_data == 16'hFFFF);
  assign is_delay = (tbl_data[15:8] == 8'hF0);

  assign snd_id   = CAMERA_ADDR;
  assign cam_pwdn = 1'b0;

  // ---------------------------------------------------------------------------
  // Sensor clock: free-running half-period counter, independent of the FSM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xclk_cnt <= '0;
      xclk     <= 1'b0;
    end else if (xclk_cnt == XCLK_LAST) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples values from before the clock edge, independent of statement order.
      xclk_cnt <= '0;
      xclk     <= ~xclk;
    end else begin
      xclk_cnt <= xclk_cnt + XW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RST;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_next      = state;
    cam_reset       = 1'b1;
    snd_send        = 1'b0;
    busy            = 1'b1;
    config_finished = 1'b0;

    case (state)
      ST_RST: begin
        cam_reset = 1'b0;
        if (pwr_cnt == RST_LAST) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (pwr_cnt == SETTLE_LAST) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        // tbl_addr is already stable; this cycle covers the table read latency.
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_end)        state_next = ST_DONE;
        else if (is_delay) state_next = ST_WAIT;
        else               state_next = ST_SEND;
      end
      ST_SEND: begin
        snd_send = 1'b1;
        if (snd_taken) state_next = ST_NEXT;
      end
      ST_WAIT: begin
        // A loaded count of 0 or 1 both leave after a single WAIT cycle; larger
        // counts spend exactly that many cycles here.
        if (dly_cnt <= DW'(1)) state_next = ST_NEXT;
      end
      ST_NEXT: begin
        // Address already advanced; wrapping to 0 means every entry was used.
        if (tbl_addr == '0) state_next = ST_DONE;
        else                state_next = ST_FETCH;
      end
      ST_DONE: begin
        busy            = 1'b0;
        config_finished = 1'b1;
        if (start) state_next = ST_FETCH;
      end
      default: begin
        state_next = ST_RST;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Power-up timer: counts RESET_CYCLES in RST, then SETTLE_CYCLES in SETTLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_cnt <= '0;
    end else begin
      case (state)
        ST_RST:    pwr_cnt <= (pwr_cnt == RST_LAST)    ? '0 : pwr_cnt + PW'(1);
        ST_SETTLE: pwr_cnt <= (pwr_cnt == SETTLE_LAST) ? '0 : pwr_cnt + PW'(1);
        default:   pwr_cnt <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Delay-tag counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt <= '0;
    end else if (state == ST_DECODE && !is_end && is_delay) begin
      dly_cnt <= DW'(tbl_data[7:0]) * DLY_UNIT_W;
    end else if (state == ST_WAIT && dly_cnt != '0) begin
      dly_cnt <= dly_cnt - DW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Table address and completed-write counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_addr  <= '0;
      cmd_count <= '0;
    end else begin
      case (state)
        ST_SEND: begin
          if (snd_taken) begin
            tbl_addr  <= tbl_addr + AW'(1);
            cmd_count <= cmd_count + CW'(1);
          end
        end
        ST_WAIT: begin
          if (dly_cnt <= DW'(1)) tbl_addr <= tbl_addr + AW'(1);
        end
        ST_DONE: begin
          if (start) begin
            tbl_addr  <= '0;
            cmd_count <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Command fields: latched once in DECODE and held through SEND.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snd_reg <= 8'h00;
      snd_val <= 8'h00;
    end else if (state == ST_DECODE && !is_end && !is_delay) begin
      snd_reg <= tbl_data[15:8];
      snd_val <= tbl_data[7:0];
    end
  end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_ov7670_config_sequencer
//
// Drives the sequencer with directed and randomly generated register tables.
// A table-walking reference model predicts the write sequence, cycle timing,
// final address and write count. A sender model accepts each command a fixed
// latency after it is raised, and injects stray taken pulses while idle.
// -----------------------------------------------------------------------------
module tb_ov7670_config_sequencer;

  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int RC    = 4;
  localparam int SC    = 8;
  localparam int DU    = 2;
  localparam int XD    = 4;
  localparam int LAT   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] tbl_addr;
  logic [15:0]   tbl_data = 16'h0000;
  logic          snd_send;
  logic [7:0]    snd_id;
  logic [7:0]    snd_reg;
  logic [7:0]    snd_val;
  logic          snd_taken = 1'b0;
  logic          cam_reset;
  logic          cam_pwdn;
  logic          xclk;
  logic          busy;
  logic          config_finished;
  logic [AW:0]   cmd_count;

  always #5 clk = ~clk;

  ov7670_config_sequencer #(
    .CAMERA_ADDR   (8'h42),
    .XCLK_DIV      (XD),
    .TABLE_DEPTH   (DEPTH),
    .RESET_CYCLES  (RC),
    .SETTLE_CYCLES (SC),
    .DELAY_UNIT    (DU)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .tbl_addr        (tbl_addr),
    .tbl_data        (tbl_data),
    .snd_send        (snd_send),
    .snd_id          (snd_id),
    .snd_reg         (snd_reg),
    .snd_val         (snd_val),
    .snd_taken       (snd_taken),
    .cam_reset       (cam_reset),
    .cam_pwdn        (cam_pwdn),
    .xclk            (xclk),
    .busy            (busy),
    .config_finished (config_finished),
    .cmd_count       (cmd_count)
  );

  // Synchronous table memory: one cycle read latency.
  logic [15:0] rom [DEPTH];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Cycle counter and posedges since the last reset release (for xclk).
  int cyc = 0;
  int pk  = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) pk = 0;
    else        pk++;
  end

  // Sender model: accepts a command LAT cycles after it is raised.
  int hold = 0;
  initial forever begin
    @(negedge clk);
    if (snd_send) begin
      hold++;
      snd_taken = (hold == LAT);
    end else begin
      hold      = 0;
      snd_taken = ($urandom_range(0, 7) == 0);
    end
  end

  // Monitor: logs commands and tracks invariants.
  logic [15:0] got_q [$];
  int          got_t [$];
  int          stable_err = 0;
  int          xclk_err = 0;
  int          pwdn_err = 0;
  int          id_err = 0;
  int          flag_err = 0;
  int          crst_low = 0;
  int          crst_rise_cyc = -1;
  logic        prev_send = 1'b0;
  logic        prev_crst = 1'b0;
  logic [15:0] cur = 16'h0000;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (snd_send && !prev_send) begin
        cur = {snd_reg, snd_val};
        got_q.push_back(cur);
        got_t.push_back(cyc);
      end else if (snd_send && ({snd_reg, snd_val} !== cur)) begin
        stable_err++;
      end
      if (cam_pwdn !== 1'b0) pwdn_err++;
      if (snd_id !== 8'h42) id_err++;
      if (xclk !== 1'((pk / (XD / 2)) % 2)) xclk_err++;
      if (busy === config_finished) flag_err++;
      if (cam_reset && !prev_crst) crst_rise_cyc = cyc;
      if (!cam_reset) crst_low++;
    end
    prev_send = snd_send;
    prev_crst = cam_reset;
  end

  // ---------------------------------------------------------------------------
  // Reference model: walk the table by its entry rules.
  // Cycle cost per entry, from the FETCH of the first entry:
  //   write: fetch + decode + LAT send cycles + next
  //   delay: fetch + decode + max(n*DU,1) wait cycles + next
  //   end:   fetch + decode, then DONE
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q [$];
  int          exp_cyc;
  int          exp_first;
  int          exp_addr;

  task automatic model();
    bit ended;
    ended     = 1'b0;
    exp_q.delete();
    exp_cyc   = 0;
    exp_first = -1;
    exp_addr  = 0;
    for (int i = 0; i < DEPTH && !ended; i++) begin
      if (rom[i] == 16'hFFFF) begin
        exp_cyc += 2;
        exp_addr = i;
        ended    = 1'b1;
      end else if (rom[i][15:8] == 8'hF0) begin
        int d;
        d = int'(rom[i][7:0]) * DU;
        exp_cyc += 3 + ((d == 0) ? 1 : d);
      end else begin
        if (exp_first < 0) exp_first = exp_cyc + 2;
        exp_q.push_back(rom[i]);
        exp_cyc += 3 + LAT;
      end
    end
  endtask

  function automatic logic [15:0] rand_write();
    return {8'($urandom_range(0, 239)), 8'($urandom_range(0, 255))};
  endfunction

  // n_live random entries followed by an end tag (none if n_live == DEPTH).
  task automatic fill_random(input int n_live);
    for (int i = 0; i < DEPTH; i++) begin
      if (i < n_live) begin
        if ($urandom_range(0, 9) < 7) rom[i] = rand_write();
        else                          rom[i] = {8'hF0, 8'($urandom_range(0, 6))};
      end else if (i == n_live) begin
        rom[i] = 16'hFFFF;
      end else begin
        rom[i] = rand_write();
      end
    end
  endtask

  task automatic fill_fixed(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    for (int i = 3; i < DEPTH; i++) rom[i] = rand_write();
    rom[0] = e0;
    rom[1] = e1;
    rom[2] = e2;
  endtask

  // ---------------------------------------------------------------------------
  // Run helpers
  // ---------------------------------------------------------------------------
  task automatic check_reset_values(input string tag);
    check({tag, "_snd_send"},  32'(snd_send), 32'(0));
    check({tag, "_cam_reset"}, 32'(cam_reset), 32'(0));
    check({tag, "_cam_pwdn"},  32'(cam_pwdn), 32'(0));
    check({tag, "_busy"},      32'(busy), 32'(1));
    check({tag, "_finished"},  32'(config_finished), 32'(0));
    check({tag, "_cmd_count"}, 32'(cmd_count), 32'(0));
    check({tag, "_tbl_addr"},  32'(tbl_addr), 32'(0));
    check({tag, "_xclk"},      32'(xclk), 32'(0));
    check({tag, "_snd_reg"},   32'(snd_reg), 32'(0));
    check({tag, "_snd_val"},   32'(snd_val), 32'(0));
  endtask

  task automatic wait_done(input string tag, input int budget, output int done_cyc);
    int n;
    n = 0;
    while (!config_finished && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_reached"}, 32'(config_finished), 32'(1));
    done_cyc = cyc;
  endtask

  task automatic check_run(input string tag, input int fetch_cyc, input int done_cyc);
    int n;
    check({tag, "_nsend"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_cmd%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    if (exp_first >= 0 && got_t.size() > 0)
      check({tag, "_first_send_cyc"}, 32'(got_t[0] - fetch_cyc), 32'(exp_first));
    check({tag, "_done_cyc"},  32'(done_cyc - fetch_cyc), 32'(exp_cyc));
    check({tag, "_cmd_count"}, 32'(cmd_count), 32'(exp_q.size()));
    check({tag, "_tbl_addr"},  32'(tbl_addr), 32'(exp_addr));
    check({tag, "_busy"},      32'(busy), 32'(0));
    check({tag, "_snd_send"},  32'(snd_send), 32'(0));
    // Stay in DONE with nothing more sent (no queued start).
    repeat (10) @(negedge clk);
    check({tag, "_idle_done"},  32'(config_finished), 32'(1));
    check({tag, "_idle_nsend"}, 32'(got_q.size()), 32'(exp_q.size()));
  endtask

  // Release reset and run the full power-up sequence; start is pulsed while
  // busy and must be ignored.
  task automatic power_up(input string tag);
    int rel;
    int d;
    got_q.delete();
    got_t.delete();
    crst_rise_cyc = -1;
    @(negedge clk);
    rst_n = 1'b1;
    rel   = cyc;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(tag, 3000, d);
    check({tag, "_cam_reset_low_cycles"}, 32'(crst_rise_cyc - rel), 32'(RC));
    check_run(tag, rel + RC + SC, d);
  endtask

  // Re-run the table from DONE; the sensor must not see a reset pulse.
  task automatic rerun(input string tag);
    int f;
    int d;
    int low0;
    got_q.delete();
    got_t.delete();
    low0 = crst_low;
    @(negedge clk);
    start = 1'b1;
    f     = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    wait_done(tag, 3000, d);
    check_run(tag, f, d);
    check({tag, "_no_cam_reset"}, 32'(crst_low - low0), 32'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;

    // Reset state and power-up with a two-write table.
    fill_fixed(16'h1280, 16'h1204, 16'hFFFF);
    model();
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    power_up("pu");

    // Delay tag ahead of a write, then a zero-length delay.
    fill_fixed(16'hF005, 16'h1100, 16'hFFFF);
    model();
    rerun("dly5");
    fill_fixed(16'hF000, 16'h1100, 16'hFFFF);
    model();
    rerun("dly0");

    // Full table of writes without an end tag: address wraps.
    for (int i = 0; i < DEPTH; i++) rom[i] = rand_write();
    model();
    rerun("full");

    // Random tables, including the empty one.
    fill_random(0);
    model();
    rerun("rnd_empty");
    for (int k = 0; k < 4; k++) begin
      fill_random($urandom_range(1, 40));
      model();
      rerun($sformatf("rnd%0d", k));
    end

    // Asynchronous reset while a command is pending.
    for (int i = 0; i < DEPTH; i++) rom[i] = rand_write();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!snd_send && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midrst_send_seen", 32'(snd_send), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_snd_send", 32'(snd_send), 32'(0));
    check("midrst_cam_reset", 32'(cam_reset), 32'(0));
    check("midrst_busy", 32'(busy), 32'(1));
    repeat (3) @(negedge clk);
    check_reset_values("midrst");
    fill_random($urandom_range(5, 30));
    model();
    power_up("repu");

    // Invariants tracked over the whole run.
    check("cmd_fields_stable", 32'(stable_err), 32'(0));
    check("xclk_period", 32'(xclk_err), 32'(0));
    check("cam_pwdn_low", 32'(pwdn_err), 32'(0));
    check("snd_id_const", 32'(id_err), 32'(0));
    check("busy_vs_finished", 32'(flag_err), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
